// File: rtl/svs_monitor_pkg.sv
// Shared widths and FSM state type for the SVS monitor sequencer.
package svs_monitor_pkg;

    localparam int unsigned SVS_TARGET_W   = 8;
    localparam int unsigned SVS_NB_MONITOR = 30;
    localparam int unsigned SVS_COUNT_W    = 16;
    localparam int unsigned SVS_IDX_W      = $clog2(SVS_NB_MONITOR);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StMeasure,
        StScan,
        StReport
    } svs_seq_state_e;

endpackage

// File: rtl/svs_monitor_seq_timer.sv
// Measurement timeout counter: expires on the enabled cycle where the count
// reaches the limit. A zero limit never expires.
module svs_monitor_seq_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [Width-1:0] i_limit,
    output logic             o_expire
);

    logic [Width-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count_q <= '0;
        end else if (i_enable) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign o_expire = i_enable && (i_limit != '0) && (count_q == i_limit - Width'(1));

endmodule

// File: rtl/svs_monitor_seq.sv
// Monitor sequencer: arms the RO monitor wrapper, captures one measurement and
// scans it for min/max. Optional timeout via SVS_MONITOR_SEQ_TIMEOUT_EN.
module svs_monitor_seq
    import svs_monitor_pkg::*;
#(
    parameter int unsigned TimeoutW = 16
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_start,
    input  logic [SVS_TARGET_W-1:0]                    i_target,
    input  logic [SVS_NB_MONITOR-1:0]                  i_use_ro,
    input  logic [SVS_COUNT_W-1:0]                     i_thr_lo,
    input  logic [SVS_COUNT_W-1:0]                     i_thr_hi,
    input  logic [TimeoutW-1:0]                        i_timeout_cycles,
    output logic                                       o_mon_enable,
    output logic [SVS_TARGET_W-1:0]                    o_mon_target,
    output logic [SVS_NB_MONITOR-1:0]                  o_mon_use_ro,
    input  logic                                       i_mon_valid,
    input  logic [SVS_NB_MONITOR-1:0][SVS_COUNT_W-1:0] i_mon_count,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic [SVS_COUNT_W-1:0]                     o_min_count,
    output logic [SVS_COUNT_W-1:0]                     o_max_count,
    output logic [SVS_IDX_W-1:0]                       o_min_idx,
    output logic                                       o_req_up,
    output logic                                       o_req_down,
    output logic                                       o_no_ro,
    output logic                                       o_timeout
);

    svs_seq_state_e state_q, state_d;

    logic [SVS_TARGET_W-1:0]                    target_q;
    logic [SVS_NB_MONITOR-1:0]                  use_ro_q;
    logic [SVS_COUNT_W-1:0]                     thr_lo_q, thr_hi_q;
    logic [SVS_NB_MONITOR-1:0][SVS_COUNT_W-1:0] counts_q;
    logic [SVS_IDX_W-1:0]                       idx_q, run_idx_q, idx_nx;
    logic [SVS_COUNT_W-1:0]                     run_min_q, run_max_q, min_nx, max_nx, cur;
    logic                                       seen_q, seen_nx, take_min, take_max;
    logic                                       last, expire, req_up_nx;

    logic [SVS_COUNT_W-1:0] min_count_q, max_count_q;
    logic [SVS_IDX_W-1:0]   min_idx_q;
    logic                   req_up_q, req_down_q, no_ro_q;

`ifdef SVS_MONITOR_SEQ_TIMEOUT_EN
    logic [TimeoutW-1:0] timeout_lim_q;
    logic                timeout_q;

    svs_monitor_seq_timer #(
        .Width(TimeoutW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (state_q != StMeasure),
        .i_enable(state_q == StMeasure),
        .i_limit (timeout_lim_q),
        .o_expire(expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timeout_lim_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && i_start) begin
                timeout_lim_q <= i_timeout_cycles;
            end
            if (state_q == StMeasure && !i_mon_valid && expire) begin
                timeout_q <= 1'b1;
            end else if (state_q == StScan && last) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^i_timeout_cycles;
    assign expire         = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    // One scan step; the first enabled RO seeds both min and max.
    always_comb begin
        cur       = counts_q[idx_q];
        take_min  = use_ro_q[idx_q] && (!seen_q || cur < run_min_q);
        take_max  = use_ro_q[idx_q] && (!seen_q || cur > run_max_q);
        min_nx    = take_min ? cur : run_min_q;
        idx_nx    = take_min ? idx_q : run_idx_q;
        max_nx    = take_max ? cur : run_max_q;
        seen_nx   = seen_q | use_ro_q[idx_q];
        last      = (idx_q == SVS_IDX_W'(SVS_NB_MONITOR - 1));
        req_up_nx = seen_nx && (min_nx < thr_lo_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (i_start) state_d = StArm;
            StArm:     if (!i_mon_valid) state_d = StMeasure;
            StMeasure: begin
                if (i_mon_valid) state_d = StScan;
                else if (expire) state_d = StReport;
            end
            StScan:    if (last) state_d = StReport;
            StReport:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            target_q    <= '0;
            use_ro_q    <= '0;
            thr_lo_q    <= '0;
            thr_hi_q    <= '0;
            counts_q    <= '0;
            idx_q       <= '0;
            run_idx_q   <= '0;
            run_min_q   <= '1;
            run_max_q   <= '0;
            seen_q      <= 1'b0;
            min_count_q <= '1;
            max_count_q <= '0;
            min_idx_q   <= '0;
            req_up_q    <= 1'b0;
            req_down_q  <= 1'b0;
            no_ro_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        target_q <= i_target;
                        use_ro_q <= i_use_ro;
                        thr_lo_q <= i_thr_lo;
                        thr_hi_q <= i_thr_hi;
                    end
                end
                StMeasure: begin
                    if (i_mon_valid) begin
                        counts_q  <= i_mon_count;
                        idx_q     <= '0;
                        run_idx_q <= '0;
                        run_min_q <= '1;
                        run_max_q <= '0;
                        seen_q    <= 1'b0;
                    end else if (expire) begin
                        min_count_q <= '1;
                        max_count_q <= '0;
                        min_idx_q   <= '0;
                        req_up_q    <= 1'b0;
                        req_down_q  <= 1'b0;
                        no_ro_q     <= (use_ro_q == '0);
                    end
                end
                StScan: begin
                    idx_q     <= idx_q + SVS_IDX_W'(1);
                    run_min_q <= min_nx;
                    run_max_q <= max_nx;
                    run_idx_q <= idx_nx;
                    seen_q    <= seen_nx;
                    if (last) begin
                        min_count_q <= min_nx;
                        max_count_q <= max_nx;
                        min_idx_q   <= idx_nx;
                        no_ro_q     <= !seen_nx;
                        req_up_q    <= req_up_nx;
                        req_down_q  <= seen_nx && !req_up_nx && (min_nx > thr_hi_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StReport);
    assign o_mon_enable = (state_q == StArm) || (state_q == StMeasure);
    assign o_mon_target = target_q;
    assign o_mon_use_ro = use_ro_q;
    assign o_min_count  = min_count_q;
    assign o_max_count  = max_count_q;
    assign o_min_idx    = min_idx_q;
    assign o_req_up     = req_up_q;
    assign o_req_down   = req_down_q;
    assign o_no_ro      = no_ro_q;

endmodule

// File: tb/tb_svs_monitor_seq.sv
// Scoreboard bench for svs_monitor_seq; timeout case built with SVS_MONITOR_SEQ_TIMEOUT_EN.
module tb_svs_monitor_seq;
    import svs_monitor_pkg::*;

    localparam int NB = SVS_NB_MONITOR;
    localparam int CW = SVS_COUNT_W;

    typedef logic [NB-1:0][CW-1:0] cnt_t;
    typedef struct {
        logic [CW-1:0]        min_c;
        logic [CW-1:0]        max_c;
        logic [SVS_IDX_W-1:0] idx;
        logic                 up;
        logic                 down;
        logic                 no_ro;
        logic                 tmo;
        int                   cap;
        int                   lat;
    } exp_t;

    logic                    i_clk, i_rst, i_start, i_mon_valid;
    logic [SVS_TARGET_W-1:0] i_target;
    logic [NB-1:0]           i_use_ro;
    logic [CW-1:0]           i_thr_lo, i_thr_hi;
    logic [15:0]             i_timeout_cycles;
    cnt_t                    i_mon_count;
    logic                    o_mon_enable, o_busy, o_done;
    logic [SVS_TARGET_W-1:0] o_mon_target;
    logic [NB-1:0]           o_mon_use_ro;
    logic [CW-1:0]           o_min_count, o_max_count;
    logic [SVS_IDX_W-1:0]    o_min_idx;
    logic                    o_req_up, o_req_down, o_no_ro, o_timeout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    svs_monitor_seq #(.TimeoutW(16)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_target        (i_target),
        .i_use_ro        (i_use_ro),
        .i_thr_lo        (i_thr_lo),
        .i_thr_hi        (i_thr_hi),
        .i_timeout_cycles(i_timeout_cycles),
        .o_mon_enable    (o_mon_enable),
        .o_mon_target    (o_mon_target),
        .o_mon_use_ro    (o_mon_use_ro),
        .i_mon_valid     (i_mon_valid),
        .i_mon_count     (i_mon_count),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_min_count     (o_min_count),
        .o_max_count     (o_max_count),
        .o_min_idx       (o_min_idx),
        .o_req_up        (o_req_up),
        .o_req_down      (o_req_down),
        .o_no_ro         (o_no_ro),
        .o_timeout       (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: min is the first-lowest enabled count, max the highest.
    function automatic exp_t model(input logic [NB-1:0] mask, input cnt_t c,
                                   input logic [CW-1:0] lo, input logic [CW-1:0] hi);
        exp_t e;
        bit   found = 0;
        e.min_c = '1;
        e.max_c = '0;
        e.idx   = '0;
        for (int k = 0; k < NB; k++) begin
            if (mask[k]) begin
                if (!found || c[k] < e.min_c) begin
                    e.min_c = c[k];
                    e.idx   = SVS_IDX_W'(k);
                end
                if (!found || c[k] > e.max_c) e.max_c = c[k];
                found = 1;
            end
        end
        e.no_ro = !found;
        e.up    = found && (e.min_c < lo);
        e.down  = found && !e.up && (e.min_c > hi);
        e.tmo   = 1'b0;
        e.cap   = 0;
        e.lat   = NB + 1;
        return e;
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=done required=no_done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("min_count", 32'(o_min_count), 32'(e.min_c));
                check("max_count", 32'(o_max_count), 32'(e.max_c));
                check("min_idx", 32'(o_min_idx), 32'(e.idx));
                check("req_up", 32'(o_req_up), 32'(e.up));
                check("req_down", 32'(o_req_down), 32'(e.down));
                check("no_ro", 32'(o_no_ro), 32'(e.no_ro));
                check("timeout", 32'(o_timeout), 32'(e.tmo));
                check("latency", 32'(cyc - e.cap), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int w = 0; w < 80 && o_busy; w++) tick();
        check(name, 32'(o_busy), 32'd0);
    endtask

    task automatic run_op(input logic [NB-1:0] mask, input cnt_t cnt, input logic [CW-1:0] lo,
                          input logic [CW-1:0] hi, input bit stale);
        exp_t                    e;
        logic [SVS_TARGET_W-1:0] tgt;
        tgt              = SVS_TARGET_W'($urandom);
        i_target         = tgt;
        i_use_ro         = mask;
        i_thr_lo         = lo;
        i_thr_hi         = hi;
        i_timeout_cycles = '0;
        i_mon_valid      = stale;
        i_mon_count      = cnt_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom});
        i_start          = 1'b1;
        tick();
        i_start  = 1'b0;
        i_target = ~tgt;
        i_use_ro = ~mask;
        i_thr_lo = ~lo;
        i_thr_hi = ~hi;
        check("arm_busy", 32'(o_busy), 32'd1);
        check("arm_enable", 32'(o_mon_enable), 32'd1);
        check("mon_target", 32'(o_mon_target), 32'(tgt));
        check("mon_use_ro", 32'(o_mon_use_ro), 32'(mask));
        if (stale) begin
            // Stale valid plus start pulses must neither capture nor restart.
            for (int s = 0; s < 3; s++) begin
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                check("stale_enable", 32'(o_mon_enable), 32'd1);
            end
        end
        i_mon_valid = 1'b0;
        tick();
        repeat ($urandom_range(0, 3)) tick();
        i_mon_count = cnt;
        i_mon_valid = 1'b1;
        e           = model(mask, cnt, lo, hi);
        e.cap       = cyc;
        sb.push_back(e);
        tick();
        i_mon_valid = 1'b0;
        i_mon_count = ~cnt;
        check("scan_enable", 32'(o_mon_enable), 32'd0);
        check("scan_target", 32'(o_mon_target), 32'(tgt));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle("op_idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_enable"}, 32'(o_mon_enable), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_min"}, 32'(o_min_count), 32'hFFFF);
        check({tag, "_max"}, 32'(o_max_count), 32'd0);
        check({tag, "_idx"}, 32'(o_min_idx), 32'd0);
        check({tag, "_req"}, 32'({o_req_up, o_req_down, o_no_ro, o_timeout}), 32'd0);
        check({tag, "_target"}, 32'(o_mon_target), 32'd0);
        check({tag, "_use_ro"}, 32'(o_mon_use_ro), 32'd0);
    endtask

    initial begin
        cnt_t          c;
        logic [NB-1:0] m;
        i_rst            = 1'b1;
        i_start          = 1'b0;
        i_mon_valid      = 1'b0;
        i_target         = '0;
        i_use_ro         = '0;
        i_thr_lo         = '0;
        i_thr_hi         = '0;
        i_timeout_cycles = '0;
        i_mon_count      = '0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check_reset_outputs("por");

        for (int k = 0; k < NB; k++) c[k] = CW'(k * 10 + 100);
        run_op('1, c, 16'd50, 16'd90, 1'b0);

        for (int k = 0; k < NB; k++) c[k] = CW'($urandom);
        c[2] = 16'd40;
        run_op(NB'(32'h0000_0004), c, 16'd50, 16'd90, 1'b0);

        run_op('0, c, 16'd50, 16'd10, 1'b0);

        for (int k = 0; k < NB; k++) c[k] = CW'($urandom_range(200, 300));
        run_op('1, c, 16'd150, 16'd250, 1'b1);

        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < NB; k++) begin
                c[k] = (n % 2 == 0) ? CW'($urandom_range(0, 7)) : CW'($urandom);
            end
            m = NB'($urandom);
            if (n % 4 == 3) m = m & NB'($urandom) & NB'($urandom);
            run_op(m, c, CW'($urandom_range(0, 40000)), CW'($urandom_range(0, 40000)),
                   bit'($urandom_range(0, 1)));
        end

        // Abort in SCAN cycle 10: no done may follow.
        for (int k = 0; k < NB; k++) c[k] = CW'(k + 500);
        i_use_ro = '1;
        i_target = 8'h5A;
        i_thr_lo = 16'd1000;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_mon_count = c;
        i_mon_valid = 1'b1;
        tick();
        i_mon_valid = 1'b0;
        repeat (10) tick();
        check("pre_abort_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_reset_outputs("abort");
        repeat (40) tick();
        check("abort_idle", 32'(o_busy), 32'd0);

`ifdef SVS_MONITOR_SEQ_TIMEOUT_EN
        begin
            exp_t e;
            i_use_ro         = NB'(32'h0000_0F0F);
            i_timeout_cycles = 16'd20;
            i_mon_valid      = 1'b0;
            i_start          = 1'b1;
            tick();
            i_start = 1'b0;
            tick();
            e       = model('0, c, '0, '0);
            e.no_ro = 1'b0;
            e.tmo   = 1'b1;
            e.cap   = cyc;
            e.lat   = 20;
            sb.push_back(e);
            wait_idle("tmo_idle");
            i_timeout_cycles = '0;
        end
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/svs_monitor_seq.md
SVS_MONITOR_SEQ -- requirements
Module: svs_monitor_seq

Interface
REQ-001 SHALL have parameter TimeoutW, default 16, width of the measurement timeout counter.
REQ-002 SHALL have port i_clk  in  1  sole clock; synchronous to the monitor functional clock input.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_start in 1 (start pulse); i_target in SVS_TARGET_W; i_use_ro in SVS_NB_MONITOR (RO enable mask).
REQ-005 SHALL have ports i_thr_lo, i_thr_hi  in  SVS_COUNT_W each  count window thresholds; i_timeout_cycles  in  TimeoutW  (0 = no timeout).
REQ-006 SHALL have ports o_mon_enable out 1; o_mon_target out SVS_TARGET_W; o_mon_use_ro out SVS_NB_MONITOR; these drive the monitor wrapper.
REQ-007 SHALL have ports i_mon_valid in 1 and i_mon_count in [SVS_NB_MONITOR][SVS_COUNT_W], both from the monitor wrapper and already synchronous to i_clk.
REQ-008 SHALL have ports o_busy 1; o_done 1 (pulse); o_min_count and o_max_count SVS_COUNT_W each; o_min_idx SVS_IDX_W; o_req_up 1; o_req_down 1; o_no_ro 1; o_timeout 1.

Function
REQ-009 SHALL implement FSM IDLE -> ARM -> MEASURE -> SCAN -> REPORT -> IDLE.
REQ-010 IDLE: i_start=1 SHALL snapshot i_target, i_use_ro, thresholds and timeout, and SHALL enter ARM next cycle; i_start outside IDLE SHALL be ignored.
REQ-011 ARM: o_mon_enable=1; SHALL stay until i_mon_valid=0 (stale-valid flush), then MEASURE.
REQ-012 MEASURE: o_mon_enable=1; on the first cycle i_mon_valid=1, SHALL capture all i_mon_count, drop o_mon_enable next cycle, enter SCAN.
REQ-013 SCAN: SHALL examine one RO per cycle, index 0..SVS_NB_MONITOR-1 (SVS_NB_MONITOR cycles); masked-off ROs SHALL not affect min/max.
REQ-014 Min tie SHALL keep lowest index; running min init all-ones, max init 0.
REQ-015 REPORT: one cycle, o_done=1, result outputs updated in the same cycle and held until the next REPORT.
REQ-016 Latency: capture cycle to o_done SHALL be exactly SVS_NB_MONITOR+1 cycles.
REQ-017 o_req_up SHALL be 1 when min < thr_lo; o_req_down SHALL be 1 when min > thr_hi and o_req_up=0 (up priority if thr_lo > thr_hi).
REQ-018 Empty mask: o_no_ro=1, min=all-ones, max=0, o_min_idx=0, o_req_up=o_req_down=0.
REQ-019 o_busy SHALL be 1 in every state except IDLE; o_mon_target/o_mon_use_ro SHALL hold snapshot values while busy.
REQ-020 Comparisons SHALL be unsigned at SVS_COUNT_W; no arithmetic widening required.

Reset
REQ-021 On i_rst=1 at an edge, the FSM SHALL enter IDLE and all outputs SHALL be 0, except o_min_count (all-ones); applies mid-operation, with o_mon_enable low from the next cycle.
REQ-022 o_done SHALL not pulse for an operation aborted by reset.

Configuration
REQ-023 With SVS_MONITOR_SEQ_TIMEOUT_EN defined, MEASURE SHALL count cycles; when i_timeout_cycles!=0 and the count reaches i_timeout_cycles, go to REPORT with o_timeout=1, req outputs 0, min/max at init values.
REQ-024 Without SVS_MONITOR_SEQ_TIMEOUT_EN, MEASURE SHALL wait indefinitely, o_timeout SHALL be tied 0, i_timeout_cycles unused.

Structure
REQ-025 svs_monitor_pkg SHALL hold SVS_TARGET_W, SVS_NB_MONITOR, SVS_COUNT_W, new SVS_IDX_W=$clog2(SVS_NB_MONITOR), and typedef svs_seq_state_e.
REQ-026 The timeout counter SHALL be sub-module svs_monitor_seq_timer (clear, enable, limit, expire), instantiated only under the macro.

Verification
REQ-027 Mask all-ones, counts k*10+100 (k=0..29), thr_lo=50, thr_hi=90 -> min=100 idx0, max=390, req_down=1, done 31 cycles after capture.
REQ-028 Mask 0x0000_0004, count[2]=40, thr_lo=50 -> min=max=40, idx=2, req_up=1, req_down=0.
REQ-029 Mask 0 -> o_no_ro=1, min=all-ones, max=0, no requests.
REQ-030 i_mon_valid high at start -> stays ARM until valid low; i_start pulses while busy -> no restart.
REQ-031 Reset asserted in SCAN cycle 10 -> IDLE, o_mon_enable=0, no o_done; with macro, timeout=20 and no valid -> o_timeout=1 after 20 MEASURE cycles.
